// File: rtl/uart_rx_deframer.sv
// 8-bit LSB-first UART receiver with 3-sample majority vote, framing/overrun flags.
// Define UART_RX_PARITY_EN to add one even-parity bit after bit 7 (8E1 frames).
module uart_rx_deframer #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  output logic       busy_o
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);

  localparam logic [CW-1:0] SMP_A  = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] SMP_B  = CW'(CPB / 2);
  localparam logic [CW-1:0] DECIDE = CW'(CPB / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [1:0]    smp;
  logic          bitval;
  logic          decide;
  logic          accept;
  logic          ferr_set;
  logic          perr_set;
`ifdef UART_RX_PARITY_EN
  logic          discard, discard_n;
`endif

  // Line is idle-high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= 2'b11;
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    else       sync <= {sync[0], rx};
  end

  assign rxs    = sync[1];
  assign decide = (cnt == DECIDE);
  assign bitval = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      smp   <= 2'b11;
`ifdef UART_RX_PARITY_EN
      discard <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      if (cnt == SMP_A) smp[0] <= rxs;
      if (cnt == SMP_B) smp[1] <= rxs;
`ifdef UART_RX_PARITY_EN
      discard <= discard_n;
`endif
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_n  = state;
    cnt_n    = (cnt == LAST) ? '0 : cnt + CW'(1);
    idx_n    = idx;
    shreg_n  = shreg;
    accept   = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    discard_n = discard;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
`ifdef UART_RX_PARITY_EN
        discard_n = 1'b0;
`endif
        if (!rxs) state_n = START;
      end
      START: begin
        if (decide && bitval) begin
          state_n = IDLE;
        end else if (cnt == LAST) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (decide) shreg_n[idx] = bitval;
        if (cnt == LAST) begin
          idx_n = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: the parity bit equals the XOR of the eight data bits.
        if (decide && (bitval != ^shreg)) begin
          perr_set  = 1'b1;
          discard_n = 1'b1;
        end
        if (cnt == LAST) state_n = STOP;
      end
`endif
      STOP: begin
        // Return to IDLE at the decision so a back-to-back start bit is caught.
        if (decide) begin
          if (bitval) begin
`ifdef UART_RX_PARITY_EN
            accept = !discard;
`else
            accept = 1'b1;
`endif
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= ferr_set;
      if (accept && (!valid_o || rd_i)) begin
        data_o  <= shreg;
        valid_o <= 1'b1;
      end else if (rd_i && valid_o) begin
        valid_o <= 1'b0;
      end
      if (accept && valid_o && !rd_i) overrun_o <= 1'b1;
      else if (rd_i && valid_o)       overrun_o <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) parity_err_o <= 1'b0;
    else       parity_err_o <= perr_set;
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: frame-level reference model plus
// directed scenarios and randomized frames with random consumer acknowledges.
module tb_uart_rx_deframer;

  localparam int CF  = 1843200;
  localparam int BD  = 115200;
  localparam int CPB = CF / BD;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Outputs for a frame starting after edge n update at edge n + STOP_OFS.
  localparam int STOP_OFS = NB * CPB + CPB / 2 + 5;
  localparam int PAR_OFS  = 9 * CPB + CPB / 2 + 5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       rd_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overrun_o, parity_err_o, busy_o;

  uart_rx_deframer #(.CLK_FREQ(CF), .BAUD(BD)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .rd_i(rd_i),
    .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .parity_err_o(parity_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  bit cmp_en = 1'b0;

  typedef enum int {EV_ACCEPT, EV_FERR, EV_PERR} ev_kind_t;
  typedef struct {
    int         at;
    ev_kind_t   kind;
    logic [7:0] d;
  } ev_t;
  ev_t evq[$];

  bit         exp_valid = 1'b0;
  bit         exp_ovr   = 1'b0;
  bit         exp_ferr  = 1'b0;
  bit         exp_perr  = 1'b0;
  logic [7:0] exp_data  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame outcomes are scheduled by the driver; consumer
  // handshake rules are applied at each edge.
  always @(posedge clk) begin : model
    bit         acc;
    logic [7:0] ad;
    cyc++;
    if (rstn) begin
      acc = 1'b0;
      ad = 8'h00;
      exp_ferr = 1'b0;
      exp_perr = 1'b0;
      for (int i = evq.size() - 1; i >= 0; i--) begin
        if (evq[i].at == cyc) begin
          case (evq[i].kind)
            EV_ACCEPT: begin acc = 1'b1; ad = evq[i].d; end
            EV_FERR:   exp_ferr = 1'b1;
            default:   exp_perr = 1'b1;
          endcase
          evq.delete(i);
        end
      end
      if (acc && (!exp_valid || rd_i)) begin
        if (exp_valid) exp_ovr = 1'b0;
        exp_data  = ad;
        exp_valid = 1'b1;
      end else if (acc) begin
        exp_ovr = 1'b1;
      end else if (rd_i && exp_valid) begin
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
      end
    end
  end

  always @(negedge rstn) begin
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_ferr  = 1'b0;
    exp_perr  = 1'b0;
    exp_data  = 8'h00;
    evq.delete();
  end

  always @(negedge clk) begin
    if (rstn && cmp_en) begin
      check("valid_o", valid_o, exp_valid);
      check("data_o", data_o, exp_data);
      check("overrun_o", overrun_o, exp_ovr);
      check("frame_err_o", frame_err_o, exp_ferr);
      check("parity_err_o", parity_err_o, exp_perr);
    end
    if (rstn && frame_err_o) ferr_cnt++;
    if (rstn && parity_err_o) perr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    rx = b;
    if (glitch) begin
      tick(CPB / 2 + 1);
      rx = ~b;
      tick(1);
      rx = b;
      tick(CPB - CPB / 2 - 2);
    end else begin
      tick(CPB);
    end
  endtask

  // Drives one frame starting now; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok,
                            input int glitch_bit);
    int   n;
    bit   pok;
    logic p;
    n = cyc;
`ifdef UART_RX_PARITY_EN
    pok = par_ok;
`else
    pok = 1'b1;
`endif
    p = (^d) ^ !par_ok;
    if (stop && pok) evq.push_back('{n + STOP_OFS, EV_ACCEPT, d});
    if (!stop) evq.push_back('{n + STOP_OFS, EV_FERR, 8'h00});
    if (!pok) evq.push_back('{n + PAR_OFS, EV_PERR, 8'h00});
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_bit);
`ifdef UART_RX_PARITY_EN
    drive_bit(p, 1'b0);
`endif
    drive_bit(stop, 1'b0);
  endtask

  task automatic rd_pulse();
    rd_i = 1'b1;
    tick(1);
    rd_i = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, f0, p0;
    bit done;
    tick(3);
    rstn = 1'b1;
    tick(2);
    check("reset valid_o", valid_o, 1'b0);
    check("reset data_o", data_o, 8'h00);
    check("reset overrun_o", overrun_o, 1'b0);
    check("reset busy_o", busy_o, 1'b0);
    check("reset frame_err_o", frame_err_o, 1'b0);
    check("reset parity_err_o", parity_err_o, 1'b0);
    cmp_en = 1'b1;

    // Basic frame, start-edge and byte latency.
    n0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, 1'b1, -1);
      begin
        tick(2);
        check("busy before 3 cycles", busy_o, 1'b0);
        tick(1);
        check("busy at 3 cycles", busy_o, 1'b1);
        tick(STOP_OFS - 4);
        check("valid before latency", valid_o, 1'b0);
        tick(1);
        check("valid at latency", valid_o, 1'b1);
      end
    join
    check("A5 data_o", data_o, 8'hA5);
    check("A5 model data", exp_data, 8'hA5);
    check("A5 busy after stop", busy_o, 1'b0);
    rd_pulse();
    check("A5 valid after rd", valid_o, 1'b0);

    // False start: short low pulse on an idle line.
    rx = 1'b0;
    tick(CPB / 4);
    rx = 1'b1;
    tick(1);
    check("false start busy", busy_o, 1'b1);
    tick(2 * CPB);
    check("false start idle", busy_o, 1'b0);
    check("false start valid", valid_o, 1'b0);

    // Framing error followed by a long break, then a good frame.
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    tick(10 * CPB);
    check("busy during break", busy_o, 1'b1);
    rx = 1'b1;
    tick(4);
    check("idle after break", busy_o, 1'b0);
    check("frame_err pulses", ferr_cnt - f0, 1);
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    tick(2);
    check("5A data_o", data_o, 8'h5A);
    check("5A valid_o", valid_o, 1'b1);
    rd_pulse();

    // Overrun, then a same-cycle acknowledge on the second stop decision.
    send_frame(8'h11, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    check("overrun data_o", data_o, 8'h11);
    check("overrun flag", overrun_o, 1'b1);
    rd_pulse();
    check("overrun cleared valid", valid_o, 1'b0);
    check("overrun cleared flag", overrun_o, 1'b0);
    send_frame(8'h11, 1'b1, 1'b1, -1);
    n0 = cyc;
    fork
      send_frame(8'h22, 1'b1, 1'b1, -1);
      begin
        tick(STOP_OFS - 1);
        rd_pulse();
      end
    join
    check("same-cycle rd data", data_o, 8'h22);
    check("same-cycle rd valid", valid_o, 1'b1);
    check("same-cycle rd overrun", overrun_o, 1'b0);
    rd_pulse();

    // Single-cycle glitch in the middle of bit 3.
    send_frame(8'h00, 1'b1, 1'b1, 3);
    tick(2);
    check("glitch data_o", data_o, 8'h00);
    check("glitch valid_o", valid_o, 1'b1);
    rd_pulse();

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, -1);
    check("parity ok data", data_o, 8'h07);
    check("parity ok valid", valid_o, 1'b1);
    rd_pulse();
    send_frame(8'h07, 1'b1, 1'b0, -1);
    tick(2);
    check("parity bad valid", valid_o, 1'b0);
    check("parity_err pulses", perr_cnt - p0, 1);
`else
    p0 = perr_cnt;
`endif

    // Reset asserted in the middle of a frame with a byte held.
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    tick(2);
    rx = 1'b0;
    tick(3 * CPB);
    rstn = 1'b0;
    #1;
    check("mid-frame reset valid", valid_o, 1'b0);
    check("mid-frame reset data", data_o, 8'h00);
    check("mid-frame reset busy", busy_o, 1'b0);
    tick(2);
    rstn = 1'b1;
    check("after release busy", busy_o, 1'b0);
    tick(3);
    check("low line restarts", busy_o, 1'b1);
    rx = 1'b1;
    tick(2 * CPB);
    check("restart false start", busy_o, 1'b0);
    check("after reset valid", valid_o, 1'b0);

    // Randomized frames with random acknowledges.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          logic [7:0] d;
          bit stp, pok;
          int g;
          d   = 8'($urandom);
          stp = ($urandom_range(0, 5) != 0);
          pok = ($urandom_range(0, 5) != 0);
          g   = $urandom_range(0, 11);
          send_frame(d, stp, pok, g);
          if (!stp) tick($urandom_range(0, 2 * CPB));
          rx = 1'b1;
          tick(4 + $urandom_range(0, 2 * CPB));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rd_i = ($urandom_range(0, 15) == 0);
          tick(1);
        end
        rd_i = 1'b0;
      end
    join
    tick(4);
    check("random pending events", evq.size(), 0);
    check("random phase perr unused", (perr_cnt >= p0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
